ahb_bus_arbiter: RTL and testbench
==================================

// Module: ahb_bus_arbiter
// PURPOSE
//  AHB-Lite multi-master bus arbiter. Shares one AHB address/data bus between NUM_MASTERS requesters.
//  Takes per-master hbusreq/hlock plus the shared hready/htrans/hburst; drives one-hot hgrant, hmaster, hmastlock.
//  Sits between the master agents' request interfaces and the bus mux; hmaster selects the address/data mux.
// PARAMETERS
//  NUM_MASTERS  integration_pkg::master_number  number of requesters, 2..16
//  DEF_MASTER   NUM_MASTERS-1                   default master when nobody requests (lowest priority)
// PORTS
//  hclk       in   1            bus clock, all state on posedge
//  hreset     in   1            asynchronous active-low reset
//  hbusreq    in   NUM_MASTERS  bus request, one bit per master
//  hlock      in   NUM_MASTERS  locked-transfer request, one bit per master
//  hready     in   1            shared transfer-done; arbiter state advances only when 1
//  htrans     in   2            current bus owner's htrans (IDLE=0,BUSY=1,NONSEQ=2,SEQ=3)
//  hburst     in   3            current bus owner's hburst (SINGLE=0,INCR=1,WRAP4..INCR16=2..7)
//  hgrant     out  NUM_MASTERS  one-hot grant, registered
//  hmaster    out  4            index of master owning the address phase, registered
//  hmastlock  out  1            owner's transfer is locked, registered
// BEHAVIOUR
//  Reset (hreset=0, async): hgrant=1<<DEF_MASTER, hmaster=DEF_MASTER, hmastlock=0, state=ARB, beat_cnt=0.
//  hready=0: every register holds (grant, hmaster, hmastlock, state, beat_cnt).
//  Priority: fixed, index 0 highest. No hbusreq bit set -> winner=DEF_MASTER.
//  hgrant: exactly one bit set at all times after reset; changes only on a cycle with hready=1 and state=ARB.
//  Grant latency: hbusreq rising at cycle N with state ARB, hready=1 -> hgrant updated at N+1.
//  Handover: on every hready=1 cycle hmaster <= index(hgrant), hmastlock <= hlock[index(hgrant)].
//   => $rose(hgrant[i]) |=> hmaster==i (given hready=1 on that edge).
//  FSM (state, 2 bits):
//   ARB:    grant re-evaluated every hready cycle. Owner (hmaster) NONSEQ with fixed-length hburst
//           (beats L=4/8/16) -> BURST, beat_cnt=L-1, grant frozen. Owner with hlock=1 and hbusreq=1 -> LOCKED.
//           SINGLE, INCR and IDLE do not freeze the grant.
//   BURST:  SEQ+hready -> beat_cnt--. BUSY does not decrement. When beat_cnt==1 and SEQ+hready:
//           arbitrate this cycle (last beat address phase), -> ARB.
//           IDLE or NONSEQ from owner (early termination) -> arbitrate this cycle, -> ARB (or re-enter BURST on NONSEQ).
//   LOCKED: grant held on owner regardless of other requests; owner hlock=0 on hready cycle -> arbitrate, -> ARB.
//  Lock has precedence over burst: locked fixed burst stays LOCKED, beat_cnt unused.
//  Simultaneous requests: lowest index wins; losers keep requesting and win later, no fairness guarantee.
//  Owner drops hbusreq mid-burst: grant still held until burst ends or IDLE seen.
//  beat_cnt width 4 bits; never underflows (saturates at 0).
//  Reset mid-burst/lock: immediate return to reset values; no pending state survives.
// STRUCTURE
//  integration_pkg: master_number, htrans_e, hburst_e enums, function burst_beats(hburst_e) -> 0/4/8/16,
//   arb_state_e {ARB, BURST, LOCKED}.
//  Sub-module ahb_prio_encoder (comb): hbusreq + DEF_MASTER -> one-hot winner + index.
//  Arbiter top: FSM, beat counter, grant/hmaster/hmastlock registers.
//  Keep request_if assertions (next_bus_master, hmastlock_same_as_hlock) bound; add onehot(hgrant) check.
// TESTING
//  Reset, hbusreq=0, hready=1 -> hgrant=1<<(NUM_MASTERS-1), hmaster=NUM_MASTERS-1, hmastlock=0 after release and for 3+ cycles.
//  hbusreq=4'b0110 at cycle N, hready=1 -> hgrant=4'b0010 at N+1, hmaster=1 at N+2.
//  M2 granted, INCR4 NONSEQ + 3 SEQ with BUSY inserted, M0 requests mid-burst -> grant stays M2 until last SEQ, then 4'b0001.
//  M3 granted with hlock=1, M0 requests for 10 cycles -> grant stays M3, hmastlock=1; hlock drops -> M0 granted next cycle.
//  hready=0 for 5 cycles while M0 requests -> hgrant/hmaster frozen; hready=1 -> grant moves 1 cycle later.
//  hreset asserted mid-INCR8 with beat_cnt=5 -> outputs at reset values same cycle; new burst arbitrated normally after release.

Source files
------------

// File: rtl/ahb_bus_arbiter_pkg.sv
// ahb_bus_arbiter_pkg
//   Shared types for the AHB-Lite bus arbiter: default master count,
//   AHB transfer/burst encodings, arbiter FSM states and the helper that
//   maps a burst encoding to its fixed beat count.
package ahb_bus_arbiter_pkg;

  localparam int unsigned master_number = 4;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'd0,
    BURST_INCR   = 3'd1,
    BURST_WRAP4  = 3'd2,
    BURST_INCR4  = 3'd3,
    BURST_WRAP8  = 3'd4,
    BURST_INCR8  = 3'd5,
    BURST_WRAP16 = 3'd6,
    BURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    BURST  = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  // Beats of a fixed-length burst; 0 for SINGLE and undefined-length INCR.
  function automatic logic [4:0] burst_beats(input hburst_e burst);
    case (burst)
      BURST_WRAP4,  BURST_INCR4:  return 5'd4;
      BURST_WRAP8,  BURST_INCR8:  return 5'd8;
      BURST_WRAP16, BURST_INCR16: return 5'd16;
      default:                    return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// ahb_bus_arbiter_if
//   Request/grant bundle between the master agents and the arbiter.
//   hbusreq/hlock  : per-master request and locked-transfer request
//   hready         : shared transfer-done
//   htrans/hburst  : transfer type and burst type of the current bus owner
//   hgrant         : one-hot grant
//   hmaster        : index of the address-phase owner (bus mux select)
//   hmastlock      : owner's transfer is locked
//   modport master : request side (drives requests, sees grants)
//   modport slave  : arbiter side (sees requests, drives grants)
interface ahb_bus_arbiter_if
  import ahb_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = master_number
) ();

  logic [NUM_MASTERS-1:0] hbusreq;
  logic [NUM_MASTERS-1:0] hlock;
  logic                   hready;
  htrans_e                htrans;
  hburst_e                hburst;
  logic [NUM_MASTERS-1:0] hgrant;
  logic [3:0]             hmaster;
  logic                   hmastlock;

  modport master (
    output hbusreq, hlock, hready, htrans, hburst,
    input  hgrant, hmaster, hmastlock
  );

  modport slave (
    input  hbusreq, hlock, hready, htrans, hburst,
    output hgrant, hmaster, hmastlock
  );

endinterface

// File: rtl/ahb_bus_arbiter_prio_encoder.sv
// ahb_bus_arbiter_prio_encoder
//   Combinational fixed-priority encoder, index 0 highest.
//   req           : request vector, one bit per master
//   winner_onehot : one-hot winning master (DEF_MASTER when req is zero)
//   winner_idx    : index of the winning master
module ahb_bus_arbiter_prio_encoder #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned DEF_MASTER  = NUM_MASTERS - 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  output logic [NUM_MASTERS-1:0] winner_onehot,
  output logic [3:0]             winner_idx
);

  always_comb begin
    winner_idx = 4'(DEF_MASTER);
    // Scan from the top so the lowest set index is the last write.
    for (int i = int'(NUM_MASTERS) - 1; i >= 0; i--) begin
      if (req[i]) winner_idx = 4'(i);
    end
  end

  always_comb begin
    winner_onehot = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      winner_onehot[i] = (winner_idx == 4'(i));
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter
//   AHB-Lite multi-master arbiter with fixed priority (index 0 highest).
//   Fixed-length bursts and locked sequences freeze the grant on the
//   current owner; otherwise the grant is re-evaluated on every hready cycle.
//   hclk   : bus clock, all state on posedge
//   hreset : asynchronous active-low reset
//   bus    : request/grant bundle (slave modport)
module ahb_bus_arbiter
  import ahb_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = master_number,
  parameter int unsigned DEF_MASTER  = NUM_MASTERS - 1
) (
  input  logic              hclk,
  input  logic              hreset,
  ahb_bus_arbiter_if.slave  bus
);

  localparam logic [NUM_MASTERS-1:0] DEF_GRANT =
    {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEF_MASTER;
  localparam logic [3:0] DEF_IDX = 4'(DEF_MASTER);

  arb_state_e             state, state_nxt;
  logic [3:0]             beat_cnt, beat_cnt_nxt;
  logic [NUM_MASTERS-1:0] hgrant_q, hgrant_nxt;
  logic [3:0]             grant_idx_q, grant_idx_nxt;
  logic [3:0]             hmaster_q;
  logic                   hmastlock_q;

  logic [NUM_MASTERS-1:0] win_onehot;
  logic [3:0]             win_idx;
  logic [NUM_MASTERS-1:0] owner_onehot;
  logic                   owner_lock;
  logic                   owner_req;
  logic                   start_lock;
  logic                   start_burst;
  logic [4:0]             beats;
  logic                   grant_lock;
  logic                   arbitrate;
  logic                   to_owner;

  ahb_bus_arbiter_prio_encoder #(
    .NUM_MASTERS (NUM_MASTERS),
    .DEF_MASTER  (DEF_MASTER)
  ) u_prio (
    .req           (bus.hbusreq),
    .winner_onehot (win_onehot),
    .winner_idx    (win_idx)
  );

  // The owner is the master in the address phase; htrans/hburst belong to it.
  always_comb begin
    owner_onehot = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      owner_onehot[i] = (hmaster_q == 4'(i));
    end
  end

  assign owner_lock  = |(bus.hlock & owner_onehot);
  assign owner_req   = |(bus.hbusreq & owner_onehot);
  assign start_lock  = owner_lock & owner_req;
  assign beats       = burst_beats(bus.hburst);
  assign start_burst = (bus.htrans == TRANS_NONSEQ) && (beats != 5'd0);
  assign grant_lock  = |(bus.hlock & hgrant_q);

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    arbitrate    = 1'b0;
    to_owner     = 1'b0;
    if (bus.hready) begin
      case (state)
        ARB: begin
          // Lock wins over burst; both pin the grant to the owner.
          if (start_lock) begin
            state_nxt    = LOCKED;
            beat_cnt_nxt = 4'd0;
            to_owner     = 1'b1;
          end else if (start_burst) begin
            state_nxt    = BURST;
            beat_cnt_nxt = 4'(beats - 5'd1);
            to_owner     = 1'b1;
          end else begin
            arbitrate = 1'b1;
          end
        end
        BURST: begin
          if (start_lock) begin
            state_nxt    = LOCKED;
            beat_cnt_nxt = 4'd0;
            to_owner     = 1'b1;
          end else begin
            case (bus.htrans)
              TRANS_SEQ: begin
                // Last beat's address phase: hand over while its data completes.
                if (beat_cnt <= 4'd1) begin
                  state_nxt    = ARB;
                  beat_cnt_nxt = 4'd0;
                  arbitrate    = 1'b1;
                end else begin
                  beat_cnt_nxt = beat_cnt - 4'd1;
                end
              end
              TRANS_BUSY: beat_cnt_nxt = beat_cnt;
              TRANS_NONSEQ: begin
                // Owner aborted and started a new transfer; a new fixed
                // burst keeps the bus, anything else releases it.
                if (beats != 5'd0) begin
                  beat_cnt_nxt = 4'(beats - 5'd1);
                end else begin
                  state_nxt    = ARB;
                  beat_cnt_nxt = 4'd0;
                  arbitrate    = 1'b1;
                end
              end
              default: begin
                state_nxt    = ARB;
                beat_cnt_nxt = 4'd0;
                arbitrate    = 1'b1;
              end
            endcase
          end
        end
        LOCKED: begin
          if (!owner_lock) begin
            state_nxt    = ARB;
            beat_cnt_nxt = 4'd0;
            arbitrate    = 1'b1;
          end
        end
        default: begin
          state_nxt    = ARB;
          beat_cnt_nxt = 4'd0;
          arbitrate    = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    hgrant_nxt    = hgrant_q;
    grant_idx_nxt = grant_idx_q;
    if (arbitrate) begin
      hgrant_nxt    = win_onehot;
      grant_idx_nxt = win_idx;
    end else if (to_owner) begin
      hgrant_nxt    = owner_onehot;
      grant_idx_nxt = hmaster_q;
    end
  end

  // Grant stage -> address-phase ownership stage (hmaster lags hgrant by one hready cycle)
  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      state       <= ARB;
      beat_cnt    <= 4'd0;
      hgrant_q    <= DEF_GRANT;
      grant_idx_q <= DEF_IDX;
      hmaster_q   <= DEF_IDX;
      hmastlock_q <= 1'b0;
    end else if (bus.hready) begin
      state       <= state_nxt;
      beat_cnt    <= beat_cnt_nxt;
      hgrant_q    <= hgrant_nxt;
      grant_idx_q <= grant_idx_nxt;
      hmaster_q   <= grant_idx_q;
      hmastlock_q <= grant_lock;
    end
  end

  assign bus.hgrant    = hgrant_q;
  assign bus.hmaster   = hmaster_q;
  assign bus.hmastlock = hmastlock_q;

  onehot_grant: assert property (@(posedge hclk) disable iff (!hreset)
    $onehot(hgrant_q));

  hmastlock_same_as_hlock: assert property (@(posedge hclk) disable iff (!hreset)
    bus.hready |=> (hmastlock_q == $past(grant_lock)));

  for (genvar gi = 0; gi < int'(NUM_MASTERS); gi++) begin : g_next_master
    next_bus_master: assert property (@(posedge hclk) disable iff (!hreset)
      (bus.hready && $rose(hgrant_q[gi])) |=> (hmaster_q == 4'(gi)));
  end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter
//   Directed bench for ahb_bus_arbiter with four masters (default master 3).
//   Each step drives the request bundle, queues the expected grant/hmaster/
//   hmastlock after the next clock edge, and compares once that edge is past.
module tb_ahb_bus_arbiter;
  import ahb_bus_arbiter_pkg::*;

  localparam int N = 4;

  logic hclk   = 1'b0;
  logic hreset = 1'b1;

  always #5 hclk = ~hclk;

  ahb_bus_arbiter_if #(.NUM_MASTERS(N)) bus ();

  ahb_bus_arbiter #(
    .NUM_MASTERS (N),
    .DEF_MASTER  (N - 1)
  ) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  typedef struct {
    string        tag;
    logic [N-1:0] grant;
    logic [3:0]   master;
    logic         lock;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [N-1:0] g, input logic [3:0] m, input logic l);
    exp_t e;
    e.tag    = tag;
    e.grant  = g;
    e.master = m;
    e.lock   = l;
    sb.push_back(e);
  endtask

  task automatic sample_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      check_eq({e.tag, "_hgrant"},    32'(bus.hgrant),    32'(e.grant));
      check_eq({e.tag, "_hmaster"},   32'(bus.hmaster),   32'(e.master));
      check_eq({e.tag, "_hmastlock"}, 32'(bus.hmastlock), 32'(e.lock));
    end
  endtask

  task automatic drive(input logic [N-1:0] req, input logic [N-1:0] lk, input logic rdy,
                       input htrans_e tr, input hburst_e bu);
    bus.hbusreq = req;
    bus.hlock   = lk;
    bus.hready  = rdy;
    bus.htrans  = tr;
    bus.hburst  = bu;
  endtask

  task automatic step(input string tag, input logic [N-1:0] req, input logic [N-1:0] lk,
                      input logic rdy, input htrans_e tr, input hburst_e bu,
                      input logic [N-1:0] eg, input logic [3:0] em, input logic el);
    drive(req, lk, rdy, tr, bu);
    expect_out(tag, eg, em, el);
    @(posedge hclk);
    #1;
    sample_out();
  endtask

  task automatic apply_reset();
    drive('0, '0, 1'b1, TRANS_IDLE, BURST_SINGLE);
    hreset = 1'b0;
    @(posedge hclk);
    @(posedge hclk);
    #1;
    hreset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    #2;
    apply_reset();

    // Reset values, then idle bus parks on the default master.
    expect_out("reset", 4'b1000, 4'd3, 1'b0);
    sample_out();
    check_eq("reset_state", 32'(dut.state), 32'(ARB));
    for (int k = 0; k < 4; k++)
      step($sformatf("idle%0d", k), 4'b0000, 4'b0000, 1'b1, TRANS_IDLE, BURST_SINGLE,
           4'b1000, 4'd3, 1'b0);

    // Simultaneous requests: lowest index wins, hmaster follows one cycle later.
    step("req0110_grant",  4'b0110, 4'b0000, 1'b1, TRANS_IDLE, BURST_SINGLE, 4'b0010, 4'd3, 1'b0);
    step("req0110_master", 4'b0110, 4'b0000, 1'b1, TRANS_IDLE, BURST_SINGLE, 4'b0010, 4'd1, 1'b0);

    // INCR4 from M2 with a BUSY beat; M0 arrives mid-burst.
    apply_reset();
    step("b4_req",    4'b0100, 4'b0000, 1'b1, TRANS_IDLE,   BURST_SINGLE, 4'b0100, 4'd3, 1'b0);
    step("b4_own",    4'b0100, 4'b0000, 1'b1, TRANS_IDLE,   BURST_SINGLE, 4'b0100, 4'd2, 1'b0);
    step("b4_nonseq", 4'b0100, 4'b0000, 1'b1, TRANS_NONSEQ, BURST_INCR4,  4'b0100, 4'd2, 1'b0);
    step("b4_seq1",   4'b0101, 4'b0000, 1'b1, TRANS_SEQ,    BURST_INCR4,  4'b0100, 4'd2, 1'b0);
    step("b4_busy",   4'b0101, 4'b0000, 1'b1, TRANS_BUSY,   BURST_INCR4,  4'b0100, 4'd2, 1'b0);
    step("b4_seq2",   4'b0101, 4'b0000, 1'b1, TRANS_SEQ,    BURST_INCR4,  4'b0100, 4'd2, 1'b0);
    step("b4_seq3",   4'b0101, 4'b0000, 1'b1, TRANS_SEQ,    BURST_INCR4,  4'b0001, 4'd2, 1'b0);
    step("b4_after",  4'b0001, 4'b0000, 1'b1, TRANS_IDLE,   BURST_SINGLE, 4'b0001, 4'd0, 1'b0);

    // Locked sequence on M3 holds off M0 until hlock drops.
    apply_reset();
    step("lk_enter", 4'b1000, 4'b1000, 1'b1, TRANS_IDLE, BURST_SINGLE, 4'b1000, 4'd3, 1'b1);
    for (int k = 0; k < 10; k++)
      step($sformatf("lk_hold%0d", k), 4'b1001, 4'b1000, 1'b1, TRANS_NONSEQ, BURST_SINGLE,
           4'b1000, 4'd3, 1'b1);
    step("lk_release", 4'b0001, 4'b0000, 1'b1, TRANS_IDLE, BURST_SINGLE, 4'b0001, 4'd3, 1'b0);
    step("lk_handover", 4'b0001, 4'b0000, 1'b1, TRANS_IDLE, BURST_SINGLE, 4'b0001, 4'd0, 1'b0);

    // Wait states freeze everything.
    apply_reset();
    for (int k = 0; k < 5; k++)
      step($sformatf("wait%0d", k), 4'b0001, 4'b0000, 1'b0, TRANS_IDLE, BURST_SINGLE,
           4'b1000, 4'd3, 1'b0);
    step("wait_end_grant",  4'b0001, 4'b0000, 1'b1, TRANS_IDLE, BURST_SINGLE, 4'b0001, 4'd3, 1'b0);
    step("wait_end_master", 4'b0001, 4'b0000, 1'b1, TRANS_IDLE, BURST_SINGLE, 4'b0001, 4'd0, 1'b0);

    // INCR8 from M1 interrupted by reset with five beats outstanding.
    apply_reset();
    step("b8_req",    4'b0010, 4'b0000, 1'b1, TRANS_IDLE,   BURST_SINGLE, 4'b0010, 4'd3, 1'b0);
    step("b8_own",    4'b0010, 4'b0000, 1'b1, TRANS_IDLE,   BURST_SINGLE, 4'b0010, 4'd1, 1'b0);
    step("b8_nonseq", 4'b0010, 4'b0000, 1'b1, TRANS_NONSEQ, BURST_INCR8,  4'b0010, 4'd1, 1'b0);
    step("b8_seq1",   4'b0011, 4'b0000, 1'b1, TRANS_SEQ,    BURST_INCR8,  4'b0010, 4'd1, 1'b0);
    step("b8_seq2",   4'b0011, 4'b0000, 1'b1, TRANS_SEQ,    BURST_INCR8,  4'b0010, 4'd1, 1'b0);
    check_eq("b8_beat_cnt", 32'(dut.beat_cnt), 32'd5);
    check_eq("b8_state",    32'(dut.state),    32'(BURST));
    #3;
    hreset = 1'b0;
    #1;
    expect_out("b8_reset", 4'b1000, 4'd3, 1'b0);
    sample_out();
    check_eq("b8_reset_cnt",   32'(dut.beat_cnt), 32'd0);
    check_eq("b8_reset_state", 32'(dut.state),    32'(ARB));
    @(posedge hclk);
    #1;
    hreset = 1'b1;

    // Fresh burst after reset, ended early by IDLE.
    step("nb_req",    4'b0100, 4'b0000, 1'b1, TRANS_IDLE,   BURST_SINGLE, 4'b0100, 4'd3, 1'b0);
    step("nb_own",    4'b0100, 4'b0000, 1'b1, TRANS_IDLE,   BURST_SINGLE, 4'b0100, 4'd2, 1'b0);
    step("nb_nonseq", 4'b0110, 4'b0000, 1'b1, TRANS_NONSEQ, BURST_INCR4,  4'b0100, 4'd2, 1'b0);
    step("nb_idle",   4'b0110, 4'b0000, 1'b1, TRANS_IDLE,   BURST_INCR4,  4'b0010, 4'd2, 1'b0);
    step("nb_next",   4'b0010, 4'b0000, 1'b1, TRANS_IDLE,   BURST_SINGLE, 4'b0010, 4'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
